// File: rtl/sgpio_master_if.sv
// SGPIO serial bus: clock, frame sync and data lines between one master and one slave.
interface sgpio_master_if;
    logic o_sgpio_clk;
    logic o_sgpio_sync;
    logic o_sgpio_mosi;
    logic i_sgpio_miso;

    modport master (
        output o_sgpio_clk,
        output o_sgpio_sync,
        output o_sgpio_mosi,
        input  i_sgpio_miso
    );

    modport slave (
        input  o_sgpio_clk,
        input  o_sgpio_sync,
        input  o_sgpio_mosi,
        output i_sgpio_miso
    );
endinterface

// File: rtl/sgpio_master.sv
// SGPIO master: streams i_user_sw to the slave and collects its LED byte, one sync + 8 data bits.
// Optional macro SGPIO_MASTER_RX_FILTER_EN: accept an LED byte only when two consecutive frames agree.
module sgpio_master #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic           i_clk,
    input  logic           i_rstn,
    input  logic           i_enable,
    input  logic [7:0]     i_user_sw,
    output logic [7:0]     o_user_led,
    output logic           o_user_led_valid,
    output logic           o_frame_done,
    output logic           o_busy,
    sgpio_master_if.master sgpio
);

    typedef enum logic [1:0] {StIdle, StSync, StData} state_e;

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [2:0] idx_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic       sclk_q;
    logic       sync_q;
    logic       mosi_q;
`ifdef SGPIO_MASTER_RX_FILTER_EN
    logic [7:0] rx_prev_q;
    logic       have_prev_q;
`endif

    logic       tick;
    logic       fall;
    logic [2:0] idx_nxt;

    assign tick    = (cnt_q == 8'(CLK_DIV - 1));
    // The half-period that ends with sclk high is the one producing the falling edge.
    assign fall    = tick & sclk_q;
    assign idx_nxt = idx_q + 3'd1;

    assign o_busy             = (state_q != StIdle);
    assign sgpio.o_sgpio_clk  = sclk_q;
    assign sgpio.o_sgpio_sync = sync_q;
    assign sgpio.o_sgpio_mosi = mosi_q;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            idx_q            <= '0;
            tx_q             <= '0;
            rx_q             <= '0;
            sclk_q           <= 1'b0;
            sync_q           <= 1'b0;
            mosi_q           <= 1'b0;
            o_user_led       <= '0;
            o_user_led_valid <= 1'b0;
            o_frame_done     <= 1'b0;
`ifdef SGPIO_MASTER_RX_FILTER_EN
            rx_prev_q        <= '0;
            have_prev_q      <= 1'b0;
`endif
        end else begin
            o_frame_done <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q  <= '0;
                    idx_q  <= '0;
                    sclk_q <= 1'b0;
                    mosi_q <= 1'b0;
                    sync_q <= i_enable;
                    if (i_enable) begin
                        tx_q    <= i_user_sw;
                        state_q <= StSync;
                    end
                end
                StSync, StData: begin
                    if (!tick) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q  <= '0;
                        sclk_q <= ~sclk_q;
                        if (fall) begin
                            if (state_q == StSync) begin
                                sync_q <= 1'b0;
                                if (i_enable) begin
                                    mosi_q   <= tx_q[0];
                                    rx_q[0]  <= sgpio.i_sgpio_miso;
                                    idx_q    <= '0;
                                    state_q  <= StData;
                                end else begin
                                    mosi_q   <= 1'b0;
                                    state_q  <= StIdle;
                                end
                            end else if (idx_q != 3'd7) begin
                                rx_q[idx_nxt] <= sgpio.i_sgpio_miso;
                                mosi_q        <= tx_q[idx_nxt];
                                idx_q         <= idx_nxt;
                            end else begin
                                // Frame end: always follow with a sync so the slave latches it.
`ifdef SGPIO_MASTER_RX_FILTER_EN
                                if (have_prev_q && (rx_q == rx_prev_q)) begin
                                    o_user_led       <= rx_q;
                                    o_user_led_valid <= 1'b1;
                                end
                                rx_prev_q   <= rx_q;
                                have_prev_q <= 1'b1;
`else
                                o_user_led       <= rx_q;
                                o_user_led_valid <= 1'b1;
`endif
                                o_frame_done <= 1'b1;
                                tx_q         <= i_user_sw;
                                sync_q       <= 1'b1;
                                mosi_q       <= 1'b0;
                                idx_q        <= '0;
                                state_q      <= StSync;
                            end
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_sgpio_master.sv
// Bench for sgpio_master: behavioural SGPIO slave plus scoreboards for LED and switch bytes.
`timescale 1ns/1ps
module tb_sgpio_master;
    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned FRAME   = 18 * CLK_DIV;
`ifdef SGPIO_MASTER_RX_FILTER_EN
    localparam bit Filter = 1'b1;
`else
    localparam bit Filter = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       enable = 1'b0;
    logic [7:0] user_sw = 8'h00;
    logic [7:0] user_led;
    logic       led_valid;
    logic       frame_done;
    logic       busy;

    sgpio_master_if bus ();

    sgpio_master #(.CLK_DIV(CLK_DIV)) dut (
        .i_clk           (clk),
        .i_rstn          (rstn),
        .i_enable        (enable),
        .i_user_sw       (user_sw),
        .o_user_led      (user_led),
        .o_user_led_valid(led_valid),
        .o_frame_done    (frame_done),
        .o_busy          (busy),
        .sgpio           (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboards: {valid, led} expected at each frame_done; bytes the slave should latch.
    logic [8:0] exp_led_q[$];
    logic [7:0] exp_sw_q[$];
    logic [7:0] m_led = 8'h00;
    logic [7:0] m_prev = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_have = 1'b0;

    function automatic void model_frame(input logic [7:0] v);
        if (Filter) begin
            if (m_have && (v == m_prev)) begin
                m_led   = v;
                m_valid = 1'b1;
            end
            m_prev = v;
            m_have = 1'b1;
        end else begin
            m_led   = v;
            m_valid = 1'b1;
        end
        exp_led_q.push_back({m_valid, m_led});
    endfunction

    // Slave: drives LED bit k after rise k (rise 0 = sync), shifts in mosi on data rises.
    logic [7:0] slave_led = 8'h3C;
    logic [7:0] s_frame_led = 8'h00;
    logic [7:0] s_sh = 8'h00;
    int         s_cnt = 0;
    logic       sclk_d = 1'b0;
    logic       mosi_d = 1'b0;

    always @(negedge clk) begin
        if (bus.o_sgpio_clk && !sclk_d) begin
            check_eq("mosi_stable_rise", bus.o_sgpio_mosi, mosi_d);
            if (bus.o_sgpio_sync) begin
                check_eq("mosi_zero_in_sync", bus.o_sgpio_mosi, 1'b0);
                if (s_cnt == 8 && exp_sw_q.size() > 0)
                    check_eq("slave_sw", s_sh, exp_sw_q.pop_front());
                s_cnt            = 0;
                s_frame_led      = slave_led;
                bus.i_sgpio_miso = slave_led[0];
            end else if (s_cnt < 8) begin
                s_sh[s_cnt] = bus.o_sgpio_mosi;
                s_cnt++;
                if (s_cnt == 1) model_frame(s_frame_led);
                if (s_cnt < 8) bus.i_sgpio_miso = s_frame_led[s_cnt];
            end
        end
        sclk_d = bus.o_sgpio_clk;
        mosi_d = bus.o_sgpio_mosi;
    end

    logic seen_c3 = 1'b0;
    always @(negedge clk) begin
        if (user_led == 8'hC3) seen_c3 = 1'b1;
        if (frame_done) begin
            check_eq("led_sb_nonempty", exp_led_q.size() != 0, 1'b1);
            if (exp_led_q.size() != 0) begin
                logic [8:0] e;
                e = exp_led_q.pop_front();
                check_eq("led_value", user_led, e[7:0]);
                check_eq("led_valid", led_valid, e[8]);
            end
        end
    end

    task automatic wait_fd(output int cycles, output int nsync);
        logic hit;
        hit    = 1'b0;
        nsync  = bus.o_sgpio_sync;
        cycles = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            cycles++;
            if (frame_done) begin
                hit = 1'b1;
                break;
            end
            if (bus.o_sgpio_sync) nsync++;
        end
        check_eq("frame_done_seen", hit, 1'b1);
    endtask

    task automatic wait_scnt(input int k);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (s_cnt == k) begin
                hit = 1'b1;
                break;
            end
        end
        check_eq("slave_bit_reached", hit, 1'b1);
    endtask

    task automatic wait_sw_drained();
        for (int i = 0; i < 4 * FRAME; i++) begin
            if (exp_sw_q.size() == 0) break;
            @(negedge clk);
        end
        check_eq("slave_sw_drained", exp_sw_q.size(), 0);
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_clk"},  bus.o_sgpio_clk,  1'b0);
        check_eq({tag, "_sync"}, bus.o_sgpio_sync, 1'b0);
        check_eq({tag, "_mosi"}, bus.o_sgpio_mosi, 1'b0);
        check_eq({tag, "_busy"}, busy,             1'b0);
        check_eq({tag, "_fd"},   frame_done,       1'b0);
    endtask

    initial begin
        int   cyc;
        int   ns;
        logic idle_hit;
        bus.i_sgpio_miso = 1'b0;
        user_sw          = 8'hA5;

        repeat (3) @(negedge clk);
        check_quiet("rst");
        check_eq("rst_led",   user_led,  8'h00);
        check_eq("rst_valid", led_valid, 1'b0);

        // Basic transfer: sw A5 out, LED 3C back.
        exp_sw_q.push_back(8'hA5);
        rstn = 1'b1;
        @(negedge clk);
        enable = 1'b1;
        wait_fd(cyc, ns);
        check_eq("valid_after_f1", led_valid, !Filter);
        wait_sw_drained();

        // Frame timing.
        wait_fd(cyc, ns);
        for (int f = 0; f < 2; f++) begin
            wait_fd(cyc, ns);
            check_eq("frame_period", cyc, FRAME);
            check_eq("sync_cycles", ns, 2 * CLK_DIV);
        end

        // Switch change mid-frame only affects the following frame.
        wait_fd(cyc, ns);
        user_sw = 8'h11;
        exp_sw_q.push_back(8'hA5);
        exp_sw_q.push_back(8'hA5);
        exp_sw_q.push_back(8'h11);
        exp_sw_q.push_back(8'h22);
        wait_fd(cyc, ns);
        repeat (10) @(negedge clk);
        user_sw = 8'h22;
        wait_fd(cyc, ns);
        wait_fd(cyc, ns);
        wait_sw_drained();

        // One-frame LED glitch.
        wait_fd(cyc, ns);
        seen_c3   = 1'b0;
        slave_led = 8'hC3;
        wait_fd(cyc, ns);
        slave_led = 8'h3C;
        wait_fd(cyc, ns);
        wait_fd(cyc, ns);
        check_eq("glitch_seen", seen_c3, !Filter);
        check_eq("led_after_glitch", user_led, 8'h3C);

        // Enable dropped during bit 3: finish, one trailing sync, then idle.
        wait_fd(cyc, ns);
        user_sw = 8'h5A;
        wait_fd(cyc, ns);
        wait_scnt(1);
        exp_sw_q.push_back(8'h5A);
        wait_scnt(3);
        enable = 1'b0;
        wait_fd(cyc, ns);
        ns       = bus.o_sgpio_sync;
        idle_hit = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_hit = 1'b1;
                break;
            end
            if (bus.o_sgpio_sync) ns++;
        end
        check_eq("idle_reached", idle_hit, 1'b1);
        check_eq("trailing_sync_cycles", ns, 2 * CLK_DIV);
        repeat (FRAME) @(negedge clk);
        check_quiet("idle");
        check_eq("slave_sw_5a_latched", exp_sw_q.size(), 0);
        check_eq("led_sb_drained", exp_led_q.size(), 0);

        // Reset during data bit 5.
        enable = 1'b1;
        wait_scnt(5);
        rstn = 1'b0;
        #1;
        check_quiet("arst");
        check_eq("arst_led",   user_led,  8'h00);
        check_eq("arst_valid", led_valid, 1'b0);
        exp_led_q.delete();
        m_led   = 8'h00;
        m_prev  = 8'h00;
        m_valid = 1'b0;
        m_have  = 1'b0;
        repeat (3) @(negedge clk);
        check_quiet("rst_hold");
        rstn = 1'b1;
        @(negedge clk);
        check_eq("sync_after_release", bus.o_sgpio_sync, 1'b1);
        check_eq("busy_after_release", busy, 1'b1);
        wait_fd(cyc, ns);
        wait_fd(cyc, ns);
        enable = 1'b0;
        idle_hit = 1'b0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            if (!busy) begin
                idle_hit = 1'b1;
                break;
            end
        end
        check_eq("final_idle", idle_hit, 1'b1);
        check_eq("final_led_sb", exp_led_q.size(), 0);
        check_eq("final_led", user_led, 8'h3C);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sgpio_master.md
SGPIO_MASTER -- requirements
Module: sgpio_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, giving the number of i_clk cycles per o_sgpio_clk half-period (legal range 1..255).
REQ-002 SHALL have port i_clk, input, 1 bit: the single system clock; all logic is on posedge i_clk.
REQ-003 SHALL have port i_rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-004 SHALL have port i_enable, input, 1 bit: high runs continuous frames; low stops after the current frame.
REQ-005 SHALL have port i_user_sw, input, 8 bits: switch value to serialize to the slave.
REQ-006 SHALL have port o_user_led, output, 8 bits: LED value received from the slave.
REQ-007 SHALL have port o_user_led_valid, output, 1 bit: o_user_led holds a received value.
REQ-008 SHALL have port o_frame_done, output, 1 bit: one-i_clk pulse at each frame completion.
REQ-009 SHALL have port o_busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port o_sgpio_clk, output, 1 bit: serial clock.
REQ-011 SHALL have port o_sgpio_sync, output, 1 bit: frame start.
REQ-012 SHALL have port o_sgpio_mosi, output, 1 bit: master-out data.
REQ-013 SHALL have port i_sgpio_miso, input, 1 bit: slave-out data, already synchronous to i_clk domain timing.

Function
REQ-014 SHALL implement states IDLE, SYNC and DATA, with a half-period counter and a 3-bit bit index; o_sgpio_clk toggles each time the counter reaches CLK_DIV-1, and then the counter wraps to 0.
REQ-015 SHALL hold o_sgpio_clk=0, o_sgpio_sync=0 and o_sgpio_mosi=0 in IDLE, with the counter held at 0.
REQ-016 SHALL, when i_enable=1 in IDLE, capture i_user_sw into a tx register, set o_sgpio_sync=1 and enter SYNC on the next cycle.
REQ-017 SHALL make all state, sync, mosi and sampling changes only on the i_clk cycle that drives o_sgpio_clk falling; a rising edge only toggles the clock.
REQ-018 SHALL, on the SYNC falling edge: if i_enable=1, clear sync, drive mosi=tx[0], sample miso into rx[0], and enter DATA with index 0; otherwise clear sync and enter IDLE, discarding the sample.
REQ-019 SHALL, on each DATA falling edge after rising edge k (k=1..7), sample miso into rx[k] and drive mosi=tx[k].
REQ-020 SHALL, on the DATA falling edge after rising edge 8: load o_user_led from rx (subject to REQ-029/030), pulse o_frame_done, capture i_user_sw into tx, set sync=1 and enter SYNC; mosi=0 while in SYNC.
REQ-021 SHALL produce a frame of exactly 9 o_sgpio_clk periods (18*CLK_DIV i_clk cycles), with sync high for exactly one period.
REQ-022 SHALL ignore i_user_sw changes outside the capture cycles, so a frame in flight is never altered.
REQ-023 SHALL, when i_enable falls mid-frame, complete the frame and send one trailing SYNC period (so the slave latches the last frame), then enter IDLE.
REQ-024 SHALL set o_user_led_valid on the first o_user_led load and clear it only by reset.

Reset
REQ-025 SHALL, while i_rstn=0, force state IDLE, counter=0 and index=0, with tx, rx and o_user_led = 8'h00.
REQ-026 SHALL, while i_rstn=0, drive o_user_led_valid, o_frame_done, o_busy, o_sgpio_clk, o_sgpio_sync and o_sgpio_mosi = 0.
REQ-027 SHALL abort any in-flight frame on reset, with no trailing sync.
REQ-028 SHALL, after reset release with i_enable=1, begin at REQ-016.

Configuration
REQ-029 SHALL, with macro SGPIO_MASTER_RX_FILTER_EN defined, load o_user_led at frame end only when rx equals the previous frame's rx; valid rises on the first such agreement, at the end of the second frame at earliest.
REQ-030 SHALL, without SGPIO_MASTER_RX_FILTER_EN, load o_user_led from rx at every frame end.

Verification
REQ-031 SHALL cover: CLK_DIV=2, enable held, sw=8'hA5, slave LED=8'h3C -> o_user_led=8'h3C with valid after frame 1 (filter off); slave switch output=8'hA5 and valid after its 2nd sync.
REQ-032 SHALL cover: CLK_DIV=2, enable held -> o_frame_done period 36 i_clk cycles; sync high 4 cycles per frame; mosi stable across each clock rise.
REQ-033 SHALL cover: enable dropped during bit 3 with sw=8'h5A -> frame completes, one trailing sync period, then IDLE with clk/sync/mosi=0 and o_busy=0; slave switch output=8'h5A.
REQ-034 SHALL cover: sw changed 8'h11->8'h22 mid-frame -> current frame sends 8'h11 and the next frame sends 8'h22.
REQ-035 SHALL cover: reset asserted at DATA bit 5 -> all outputs 0 immediately; after release with enable=1, sync reasserted within 1 cycle.
REQ-036 SHALL cover: LED 8'h3C, then 8'hC3 for one frame, then back to 8'h3C -> with filter, o_user_led stays 8'h3C; without filter, o_user_led shows 8'hC3 for one frame.
